// File: rtl/logic_unit_pipe.sv
// ----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered two-operand bitwise logic unit with a valid/ready handshake and
//   a 2-entry in-order output buffer. The result is computed from a/b/op at
//   accept and stored in the buffer; y/out_valid are driven from the head
//   register.
//
//   Parameters:
//     WIDTH  operand/result width (>=1)
//     CNT_W  width of the accepted-transaction counter
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   operand beat valid
//     in_ready   out  buffer has a free slot (registered)
//     a, b       in   operands
//     op         in   operation select (0 and,1 or,2 xor,3 nand,4 nor,
//                     5 xnor,6 a&~b,7 pass a)
//     out_valid  out  head entry holds a result
//     out_ready  in   downstream accepts the head result
//     y          out  head result (holds last value when out_valid=0)
//     txn_count  out  accepted-beat counter, wraps
//
//   Optional feature (macro LOGIC_UNIT_REDUCE_EN):
//     y_and, y_or, y_xor  out  AND/OR/XOR reductions of the head result,
//                              stored per buffer entry alongside y.
// ----------------------------------------------------------------------------
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] txn_count
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    output logic             y_and,
    output logic             y_or,
    output logic             y_xor
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    occ_t             occ, occ_next;
    logic             ready_q;
    logic             push, pop;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] head, tail;
    logic             load_head, load_tail, shift;

    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;
    assign out_valid = (occ != OCC_EMPTY);
    assign in_ready  = ready_q;
    assign y         = head;

    always_comb begin
        result = '0;
        case (op)
            3'd0: result = a & b;
            3'd1: result = a | b;
            3'd2: result = a ^ b;
            3'd3: result = ~(a & b);
            3'd4: result = ~(a | b);
            3'd5: result = ~(a ^ b);
            3'd6: result = a & ~b;
            default: result = a;
        endcase
    end

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (push) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_next = OCC_FULL;
                else if (!push && pop) occ_next = OCC_EMPTY;
            end
            OCC_FULL: if (pop) occ_next = OCC_ONE;
            default: occ_next = OCC_EMPTY;
        endcase
    end

    // in_ready is registered from next occupancy, so it never depends
    // combinationally on out_ready; it is 0 during reset and rises on the
    // first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= OCC_EMPTY;
            ready_q <= 1'b0;
        end else begin
            occ     <= occ_next;
            ready_q <= (occ_next != OCC_FULL);
        end
    end

    // New result goes straight to head when the buffer is empty or when the
    // single entry is popped in the same cycle (no bubble); otherwise it
    // waits in tail until the head is popped.
    assign load_head = push && ((occ == OCC_EMPTY) || ((occ == OCC_ONE) && pop));
    assign load_tail = push && (occ == OCC_ONE) && !pop;
    assign shift     = pop && (occ == OCC_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (shift)          head <= tail;
            else if (load_head) head <= result;
            if (load_tail)      tail <= result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    txn_count <= '0;
        else if (push) txn_count <= txn_count + 1'b1;
    end

`ifdef LOGIC_UNIT_REDUCE_EN
    logic [2:0] result_red, head_red, tail_red;

    assign result_red = {&result, |result, ^result};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_red <= '0;
            tail_red <= '0;
        end else begin
            if (shift)          head_red <= tail_red;
            else if (load_head) head_red <= result_red;
            if (load_tail)      tail_red <= result_red;
        end
    end

    assign y_and = head_red[2];
    assign y_or  = head_red[1];
    assign y_xor = head_red[0];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// ----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Scoreboard bench for logic_unit_pipe (WIDTH=8, CNT_W=4). Expected results
//   are pushed at accept; a negedge monitor compares the head of the queue
//   against y whenever out_valid is high and pops on out_valid & out_ready.
// ----------------------------------------------------------------------------
module tb_logic_unit_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic [2:0]    op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic [CW-1:0] txn_count;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic          y_and, y_or, y_xor;
`endif

    logic [W-1:0] exp_q[$];
    int           cnt_model = 0;
    int           checks    = 0;
    int           errors    = 0;
    bit           rand_done = 0;

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .txn_count (txn_count)
`ifdef LOGIC_UNIT_REDUCE_EN
        ,
        .y_and     (y_and),
        .y_or      (y_or),
        .y_xor     (y_xor)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] z,
                                           input logic [2:0] o);
        logic [W-1:0] r;
        case (o)
            3'd0: r = x & z;
            3'd1: r = x | z;
            3'd2: r = x ^ z;
            3'd3: r = ~(x & z);
            3'd4: r = ~(x | z);
            3'd5: r = ~(x ^ z);
            3'd6: r = x & ~z;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one beat; returns the number of cycles until it was accepted.
    task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [2:0] op_i, output int tries);
        bit acc = 0;
        tries    = 0;
        in_valid = 1'b1;
        a        = a_i;
        b        = b_i;
        op       = op_i;
        while (!acc && tries < 200) begin
            @(negedge clk);
            tries++;
            if (in_ready) begin
                exp_q.push_back(model(a_i, b_i, op_i));
                cnt_model = (cnt_model + 1) % 16;
                acc = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        else      chk("txn_count", 32'(txn_count), 32'(cnt_model));
    endtask

    task automatic wait_drain();
        int i = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(y), 32'hFFFF_FFFF);
            end else begin
                chk("y", 32'(y), 32'(exp_q[0]));
`ifdef LOGIC_UNIT_REDUCE_EN
                chk("y_and", 32'(y_and), 32'(&exp_q[0]));
                chk("y_or",  32'(y_or),  32'(|exp_q[0]));
                chk("y_xor", 32'(y_xor), 32'(^exp_q[0]));
`endif
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    logic [W-1:0] sweep_exp [8];
    int           t;

    initial begin
        sweep_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30, 8'hF0};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_txn_count", 32'(txn_count), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Op sweep: result visible one cycle after accept
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'hF0, 8'hCC, 3'(i), t);
            chk("sweep_valid", 32'(out_valid), 32'd1);
            chk("sweep_y", 32'(y), 32'(sweep_exp[i]));
        end
        wait_drain();

        // Back-pressure: two accepts fill the buffer, third beat is held
        out_ready = 1'b0;
        fork
            begin
                send(8'hFF, 8'h0F, 3'd0, t);
                send(8'hFF, 8'h33, 3'd0, t);
                send(8'hFF, 8'h55, 3'd0, t);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_head", 32'(y), 32'h0F);
                chk("bp_txn", 32'(txn_count), 32'(cnt_model));
                repeat (3) @(posedge clk);
                #2;
                chk("bp_head_stable", 32'(y), 32'h0F);
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-operation with two results buffered
        out_ready = 1'b0;
        send(8'h12, 8'h34, 3'd1, t);
        send(8'h56, 8'h78, 3'd2, t);
        chk("mid_full", 32'(in_ready), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_txn", 32'(txn_count), 32'd0);
        exp_q.delete();
        cnt_model = 0;
        #10 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);

        // Streaming: one accept per cycle, counter wraps 15 -> 0 -> 4
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), t);
            chk("stream_tries", 32'(t), 32'd1);
        end
        chk("stream_wrap", 32'(txn_count), 32'd4);
        wait_drain();

        // Reduction corner values (pass-through op)
        send(8'hFF, 8'h00, 3'd7, t);
        chk("red_ff", 32'(y), 32'hFF);
`ifdef LOGIC_UNIT_REDUCE_EN
        chk("red_ff_and", 32'(y_and), 32'd1);
        chk("red_ff_or",  32'(y_or),  32'd1);
        chk("red_ff_xor", 32'(y_xor), 32'd0);
`endif
        send(8'h01, 8'h00, 3'd7, t);
        chk("red_01", 32'(y), 32'h01);
`ifdef LOGIC_UNIT_REDUCE_EN
        chk("red_01_and", 32'(y_and), 32'd0);
        chk("red_01_or",  32'(y_or),  32'd1);
        chk("red_01_xor", 32'(y_xor), 32'd1);
`endif
        send(8'h00, 8'hFF, 3'd7, t);
        chk("red_00", 32'(y), 32'h00);
`ifdef LOGIC_UNIT_REDUCE_EN
        chk("red_00_and", 32'(y_and), 32'd0);
        chk("red_00_or",  32'(y_or),  32'd0);
        chk("red_00_xor", 32'(y_xor), 32'd0);
`endif
        wait_drain();

        // Random traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    send(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), t);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #2 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
